// File: rtl/svp_capture_pkg.sv
// Shared types and constants for the SV-side capture stage: cycle stamp type,
// record width helper and the drop-counter ceiling.
package svp_capture_pkg;

  typedef logic [63:0] svp_stamp_t;

  localparam int          SVP_STAMP_W  = 64;
  localparam logic [15:0] SVP_DROP_MAX = 16'hFFFF;

  // Packed width of a {stamp, data} record for a given sample width.
  function automatic int svp_rec_w(input int data_w);
    return SVP_STAMP_W + data_w;
  endfunction

endpackage

// File: rtl/svp_sync_fifo.sv
// Single-clock register-array FIFO; a push into a full FIFO is still taken
// when a pop happens on the same edge.
module svp_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         pop_ok;
  logic         push_ok;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    wr_d    = wr_q + {{AW{1'b0}}, push_ok};
    rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
    level_o = wr_q - rd_q;
    // Head is forced to zero when empty so stale entries never leak out.
    rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full with a pop, the write slot is the slot being vacated.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/svp_capture_fifo.sv
// Capture stage: decimates the sample stream, stamps kept samples with a
// 64-bit cycle count and buffers them for a valid/ready consumer.
module svp_capture_fifo
  import svp_capture_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16,
  parameter int DECW  = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [DECW-1:0]        dec_ratio,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output svp_stamp_t             out_stamp,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int RW = svp_rec_w(WIDTH);

  typedef struct packed {
    svp_stamp_t       stamp;
    logic [WIDTH-1:0] data;
  } rec_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SVP_DROP_MAX) ? v : v + 16'd1;
  endfunction

  svp_stamp_t      stamp_q;
  logic [DECW-1:0] phase_q, phase_d;
  logic [DECW-1:0] ratio_q;
  logic [DECW-1:0] eff_ratio;
  logic            ratio_chg;
  logic            accept;
  logic            keep;
  logic            pop;
  logic            drop;
  logic            full;
  logic            empty;
  logic            overflow_q;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  rec_t            wr_rec;
  rec_t            rd_rec;

  always_comb begin
    eff_ratio = (dec_ratio == '0) ? DECW'(1) : dec_ratio;
    ratio_chg = (dec_ratio != ratio_q);
    accept    = in_valid & en;
    keep      = accept & (phase_q == '0);
    phase_d   = phase_q;
    // The change-cycle sample already used the old phase via keep above.
    if (ratio_chg) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d = (phase_q == eff_ratio - DECW'(1)) ? '0 : phase_q + DECW'(1);
    end
  end

  always_comb begin
    wr_rec.stamp = stamp_q;
    wr_rec.data  = in_data;
    pop          = out_ready & ~empty;
    drop         = keep & full & ~pop;
    drop_cnt_d   = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  // ratio_q follows dec_ratio even in reset so release is not seen as a change.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      stamp_q    <= '0;
      phase_q    <= '0;
      ratio_q    <= dec_ratio;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      stamp_q    <= stamp_q + 64'd1;
      phase_q    <= phase_d;
      ratio_q    <= dec_ratio;
      overflow_q <= overflow_q | drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  svp_sync_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (keep),
    .wdata_i (wr_rec),
    .pop_i   (out_ready),
    .rdata_o (rd_rec),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign out_valid = ~empty;
  assign out_data  = rd_rec.data;
  assign out_stamp = rd_rec.stamp;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_svp_capture_fifo.sv
// Scoreboard bench for svp_capture_fifo: a driver feeds directed and random
// stimulus into a queue-based reference model; a monitor checks every pop.
module tb_svp_capture_fifo;
  localparam int WIDTH = 14;
  localparam int DEPTH = 16;
  localparam int DECW  = 8;

  logic              clk;
  logic              rstb;
  logic              en;
  logic [DECW-1:0]   dec_ratio;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [63:0]       out_stamp;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic [4:0]        level;

  svp_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DECW  (DECW)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .dec_ratio (dec_ratio),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_stamp (out_stamp),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [63+WIDTH:0] exp_q [$];
  int                occ;
  longint unsigned   cyc;
  int                nacc;
  int                epoch_eff;
  logic [DECW-1:0]   prev_ratio;
  logic              m_ovf;
  int                m_drop;

  function automatic int eff(input logic [DECW-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the coming edge whenever valid & ready.
  always @(negedge clk) begin
    if (rstb === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 64'd1, 64'd0);
      end else begin
        logic [63+WIDTH:0] e;
        e = exp_q.pop_front();
        chk("out_stamp", out_stamp, e[63+WIDTH:WIDTH]);
        chk("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
      end
    end
  end

  // One cycle: apply inputs, advance the model, then check registered status.
  task automatic step(input logic r, input logic e, input logic [DECW-1:0] rat,
                      input logic iv, input logic [WIDTH-1:0] d, input logic rdy);
    logic pop;
    logic keep;
    rstb = r; en = e; dec_ratio = rat; in_valid = iv; in_data = d; out_ready = rdy;
    if (!r) begin
      exp_q.delete();
      occ = 0; cyc = 0; nacc = 0;
      prev_ratio = rat; epoch_eff = eff(rat);
      m_ovf = 1'b0; m_drop = 0;
    end else begin
      pop  = rdy && (occ > 0);
      keep = iv && e && ((nacc % epoch_eff) == 0);
      if (iv && e) nacc++;
      if (rat != prev_ratio) begin
        nacc = 0;
        epoch_eff = eff(rat);
      end
      prev_ratio = rat;
      if (keep) begin
        if (occ < DEPTH || pop) begin
          exp_q.push_back({cyc, d});
          occ++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 65535) m_drop++;
        end
      end
      if (pop) occ--;
      cyc++;
    end
    @(posedge clk);
    #1;
    chk("level", 64'(level), 64'(occ));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 8'd1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    rstb = 1'b0; en = 1'b0; dec_ratio = 8'd1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    occ = 0; cyc = 0; nacc = 0; epoch_eff = 1; prev_ratio = 8'd1; m_ovf = 1'b0; m_drop = 0;
    @(posedge clk);
    #1;

    // Reset held with input activity
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd1, 1'b1, 14'h3FFF, 1'b1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_stamp", out_stamp, 64'd0);

    // Ratio 1 ramp, consumer always ready
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 8'd1, 1'b1, WIDTH'(i), 1'b1);
      chk("ramp_level_le1", 64'(level <= 5'd1), 64'd1);
    end
    drain(3);

    // Ratio 4, switched to 3 at cycle 10
    step(1'b0, 1'b0, 8'd4, 1'b0, '0, 1'b0);
    for (int c = 0; c < 30; c++)
      step(1'b1, 1'b1, (c >= 10) ? 8'd3 : 8'd4, 1'b1, WIDTH'(c), 1'b1);
    drain(3);

    // Overflow with consumer stalled
    step(1'b0, 1'b0, 8'd1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'd1, 1'b1, WIDTH'(i + 7), 1'b0);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    drain(DEPTH + 2);
    chk("ovf_flag_sticky", 64'(overflow), 64'd1);

    // Full FIFO with simultaneous pop and push
    step(1'b0, 1'b0, 8'd1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'd1, 1'b1, WIDTH'(i + 200), 1'b0);
    step(1'b1, 1'b1, 8'd1, 1'b1, 14'd999, 1'b1);
    chk("fullpop_level", 64'(level), 64'd16);
    chk("fullpop_overflow", 64'(overflow), 64'd0);
    drain(DEPTH + 2);

    // Reset mid-run with records buffered
    step(1'b0, 1'b0, 8'd1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'd1, 1'b1, WIDTH'(i + 50), 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 14'd77, 1'b1);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    step(1'b1, 1'b1, 8'd1, 1'b1, 14'd123, 1'b1);
    chk("midrst_stamp0", out_stamp, 64'd0);
    drain(2);

    // Randomized traffic with ratio changes, enable gaps and rare resets
    begin
      logic [DECW-1:0] rat;
      rat = 8'd2;
      for (int i = 0; i < 3000; i++) begin
        logic [7:0] rsel [5];
        rsel[0] = 8'd0; rsel[1] = 8'd1; rsel[2] = 8'd2; rsel[3] = 8'd3; rsel[4] = 8'd5;
        if ($urandom_range(0, 39) == 0) rat = rsel[$urandom_range(0, 4)];
        step(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 7) != 0),
             rat,
             ($urandom_range(0, 3) != 0),
             WIDTH'($urandom),
             ($urandom_range(0, 2) != 0));
      end
    end
    drain(DEPTH + 4);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
